fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_pkg.sv | 44 ++++
 rtl/fp_lzc.sv | 22 ++
 rtl/fp_mul_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier.
//   rm_e           rounding-mode encoding carried with each operation
//   fp_class_t     special-operand classification travelling down the pipe
//   FLAG_*         bit positions inside the 4-bit flags word
//   fp_bias        exponent bias for a given exponent width
//   fp_canon_nan   canonical quiet NaN pattern (sign 0, exp all ones, frac MSB 1)
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_e;

    typedef struct packed {
        logic nan;
        logic invalid;
        logic inf;
        logic zero;
    } fp_class_t;

    localparam int FLAG_W         = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned wide; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   i_data  vector to scan, MSB first
//   o_cnt   number of zeros above the most significant one; WIDTH when all zero
module fp_lzc #(
    parameter  int WIDTH = 22,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt
);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-style floating-point multiplier with flush-to-zero.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake; in_ready = ~out_valid | out_ready
//   a, b                   operands, 1+EXP_W+MAN_W bits each
//   rm                     rounding mode (fp_pkg::rm_e)
//   in_tag                 opaque tag returned on out_tag
//   out_valid / out_ready  result handshake; everything holds while stalled
//   out, out_tag           product and its tag
//   flags                  {invalid, overflow, underflow, inexact}
// Stages: 1 unpack/multiply, 2 normalise/round, 3 pack/special-select.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [TAG_W-1:0]       out_tag,
    output logic [FLAG_W-1:0]      flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW   = EXP_W + 3;
    localparam int CW   = $clog2(PW + 1);
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic [63:0]           NAN64     = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]          CANON_NAN = NAN64[W-1:0];
    localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]      EXP_MAXF  = EXP_W'((2 ** EXP_W) - 2);
    localparam logic signed [EW-1:0]  EXP_OVF   = EW'((2 ** EXP_W) - 1);

    // ---------------- handshake / global stall ----------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_adv1, w_adv2, w_adv3, w_accept;

    // A stage may load when its own slot is empty or its occupant moves on,
    // so bubbles collapse even while the output is stalled.
    assign w_adv3   = ~r3_valid | out_ready;
    assign w_adv2   = ~r2_valid | w_adv3;
    assign w_adv1   = ~r1_valid | w_adv2;
    assign in_ready = w_adv3;
    assign w_accept = in_valid & in_ready;

    // ---------------- stage 1: unpack / multiply ----------------
    logic [EXP_W-1:0]     w_ea, w_eb, w_eff_a, w_eff_b;
    logic [MAN_W-1:0]     w_fa, w_fb;
    logic [MAN_W:0]       w_sig_a, w_sig_b;
    logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic                 w_a_snan, w_b_snan, w_inf_zero;
    logic [PW-1:0]        w_prod;
    logic signed [EW-1:0] w_exp_sum;
    fp_class_t            w_cls;

    assign w_ea = a[W-2:MAN_W];
    assign w_eb = b[W-2:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_fb = b[MAN_W-1:0];

    assign w_a_zero = (w_ea == '0) && (w_fa == '0);
    assign w_b_zero = (w_eb == '0) && (w_fb == '0);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
    assign w_inf_zero = (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);

    assign w_cls.nan     = w_a_nan | w_b_nan | w_inf_zero;
    assign w_cls.invalid = w_a_snan | w_b_snan | w_inf_zero;
    assign w_cls.inf     = w_a_inf | w_b_inf;
    assign w_cls.zero    = w_a_zero | w_b_zero;

    // Subnormals have no hidden bit but behave as exponent 1.
    assign w_sig_a = {(w_ea != '0), w_fa};
    assign w_sig_b = {(w_eb != '0), w_fb};
    assign w_eff_a = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eff_b = (w_eb == '0) ? EXP_W'(1) : w_eb;

    assign w_prod    = {{(MAN_W+1){1'b0}}, w_sig_a} * {{(MAN_W+1){1'b0}}, w_sig_b};
    assign w_exp_sum = EW'(w_eff_a) + EW'(w_eff_b) - EW'(BIAS);

    logic                 r1_sign;
    logic [PW-1:0]        r1_prod;
    logic signed [EW-1:0] r1_exp;
    fp_class_t            r1_cls;
    rm_e                  r1_rm;
    logic [TAG_W-1:0]     r1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
        end else if (w_adv1) begin
            r1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r1_sign <= a[W-1] ^ b[W-1];
            r1_prod <= w_prod;
            r1_exp  <= w_exp_sum;
            r1_cls  <= w_cls;
            r1_rm   <= rm_e'(rm);
            r1_tag  <= in_tag;
        end
    end

    // ---------------- stage 2: normalise / round ----------------
    logic [CW-1:0]        w_lzc;
    logic [PW-1:0]        w_norm;
    logic signed [EW-1:0] w_exp_n, w_exp_r;
    logic                 w_g, w_r, w_s, w_inexact, w_up;
    logic [MAN_W+1:0]     w_rnd;

    fp_lzc #(.WIDTH(PW)) u_lzc (
        .i_data (r1_prod),
        .o_cnt  (w_lzc)
    );

    // Leading one lands on bit PW-1, which carries weight 2^1 before the shift.
    assign w_norm    = r1_prod << w_lzc;
    assign w_exp_n   = r1_exp - EW'(w_lzc) + EW'(1);
    assign w_g       = w_norm[PW-2-MAN_W];
    assign w_r       = w_norm[PW-3-MAN_W];
    assign w_s       = |w_norm[PW-4-MAN_W:0];
    assign w_inexact = w_g | w_r | w_s;

    always_comb begin
        w_up = 1'b0;
        case (r1_rm)
            RM_RNE:  w_up = w_g & (w_r | w_s | w_norm[PW-1-MAN_W]);
            RM_RTZ:  w_up = 1'b0;
            RM_RUP:  w_up = ~r1_sign & w_inexact;
            RM_RDN:  w_up = r1_sign & w_inexact;
            default: w_up = 1'b0;
        endcase
    end

    // Significand incl. hidden bit plus the increment; a carry out means the
    // fraction wrapped to zero and the exponent steps up by one.
    assign w_rnd   = {1'b0, w_norm[PW-1 -: MAN_W+1]} + (MAN_W+2)'(w_up);
    assign w_exp_r = w_exp_n + EW'(w_rnd[MAN_W+1]);

    logic                 r2_sign, r2_inexact;
    logic [MAN_W-1:0]     r2_frac;
    logic signed [EW-1:0] r2_exp;
    fp_class_t            r2_cls;
    rm_e                  r2_rm;
    logic [TAG_W-1:0]     r2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
        end else if (w_adv2) begin
            r2_valid <= r1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv2 && r1_valid) begin
            r2_sign    <= r1_sign;
            r2_frac    <= w_rnd[MAN_W-1:0];
            r2_exp     <= w_exp_r;
            r2_inexact <= w_inexact;
            r2_cls     <= r1_cls;
            r2_rm      <= r1_rm;
            r2_tag     <= r1_tag;
        end
    end

    // ---------------- stage 3: pack / special-select ----------------
    logic              w_ovf, w_unf, w_ovf_inf;
    logic [W-1:0]      w_out;
    logic [FLAG_W-1:0] w_flags;

    assign w_ovf     = (r2_exp >= EXP_OVF);
    assign w_unf     = r2_exp[EW-1] || (r2_exp == '0);
    assign w_ovf_inf = (r2_rm == RM_RNE) ||
                       ((r2_rm == RM_RUP) && !r2_sign) ||
                       ((r2_rm == RM_RDN) && r2_sign);

    always_comb begin
        w_out   = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
        w_flags = '0;
        w_flags[FLAG_INEXACT] = r2_inexact;
        if (r2_cls.nan) begin
            w_out   = CANON_NAN;
            w_flags = '0;
            w_flags[FLAG_INVALID] = r2_cls.invalid;
        end else if (r2_cls.inf) begin
            w_out   = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flags = '0;
        end else if (r2_cls.zero) begin
            w_out   = {r2_sign, {(W-1){1'b0}}};
            w_flags = '0;
        end else if (w_ovf) begin
            w_out   = w_ovf_inf ? {r2_sign, EXP_ONES, {MAN_W{1'b0}}}
                                : {r2_sign, EXP_MAXF, {MAN_W{1'b1}}};
            w_flags = '0;
            w_flags[FLAG_OVERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
        end else if (w_unf) begin
            w_out   = {r2_sign, {(W-1){1'b0}}};
            w_flags = '0;
            w_flags[FLAG_UNDERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
        end
    end

    // Output registers are reset so the port reads zero after reset.
    logic [W-1:0]      r3_out;
    logic [TAG_W-1:0]  r3_tag;
    logic [FLAG_W-1:0] r3_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_out   <= '0;
            r3_tag   <= '0;
            r3_flags <= '0;
        end else if (w_adv3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_out   <= w_out;
                r3_tag   <= r2_tag;
                r3_flags <= w_flags;
            end
        end
    end

    assign out_valid = r3_valid;
    assign out       = r3_out;
    assign out_tag   = r3_tag;
    assign flags     = r3_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [1:0]  rm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [3:0]  out_tag;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  rm;
        logic [15:0] o;
        logic [3:0]  f;
    } vec_t;

    fp_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb,
                                input logic [1:0] vrm, input logic [15:0] vo,
                                input logic [3:0] vf);
        vec_t v;
        v.a = va; v.b = vb; v.rm = vrm; v.o = vo; v.f = vf;
        return v;
    endfunction

    // Issue one op into an empty pipe (called #1 after a rising edge), wait
    // bounded for the result, capture it, then let it drain. lat = -1 on timeout.
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [1:0] irm, input logic [3:0] itag,
                         output logic [15:0] o, output logic [3:0] f,
                         output logic [3:0] t, output int lat);
        in_valid = 1'b1; a = ia; b = ib; rm = irm; in_tag = itag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        o = out; f = flags; t = out_tag;
        if (!out_valid) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; rm = 2'd0; in_tag = '0;
        #1 rst_n = 1'b0;
        #10;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out !== 16'h0000)   begin n_fail++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_checks++; if (out_tag !== 4'h0)   begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        n_checks++; if (flags !== 4'h0)     begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] o; logic [3:0] f, t; int lat;
        vec_t v[$];
        v.push_back(mk(16'h3C00, 16'h3C00, 2'd0, 16'h3C00, 4'b0000));  // 1*1
        v.push_back(mk(16'h4000, 16'h4200, 2'd0, 16'h4600, 4'b0000));  // 2*3 = 6
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].rm, 4'(i + 5), o, f, t, lat);
            n_checks++; if (o !== v[i].o)   begin n_fail++; $display("FAIL basic[%0d] out: got %h expected %h", i, o, v[i].o); end
            n_checks++; if (f !== v[i].f)   begin n_fail++; $display("FAIL basic[%0d] flags: got %b expected %b", i, f, v[i].f); end
            n_checks++; if (t !== 4'(i + 5)) begin n_fail++; $display("FAIL basic[%0d] tag: got %h expected %h", i, t, 4'(i + 5)); end
            n_checks++; if (lat !== 3)      begin n_fail++; $display("FAIL basic[%0d] latency: got %0d expected 3", i, lat); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] o; logic [3:0] f, t; int lat;
        vec_t v[$];
        v.push_back(mk(16'h7BFF, 16'h4000, 2'd0, 16'h7C00, 4'b0101));  // RNE -> +inf
        v.push_back(mk(16'h7BFF, 16'h4000, 2'd1, 16'h7BFF, 4'b0101));  // RTZ -> max finite
        v.push_back(mk(16'hFBFF, 16'h4000, 2'd3, 16'hFC00, 4'b0101));  // RDN, negative -> -inf
        v.push_back(mk(16'hFBFF, 16'h4000, 2'd2, 16'hFBFF, 4'b0101));  // RUP, negative -> -max
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].rm, 4'(i), o, f, t, lat);
            n_checks++; if (o !== v[i].o) begin n_fail++; $display("FAIL ovf[%0d] out: got %h expected %h", i, o, v[i].o); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL ovf[%0d] flags: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_special();
        logic [15:0] o; logic [3:0] f, t; int lat;
        vec_t v[$];
        v.push_back(mk(16'h7C00, 16'h0000, 2'd0, 16'h7E00, 4'b1000));  // inf*0
        v.push_back(mk(16'h0000, 16'hFC00, 2'd0, 16'h7E00, 4'b1000));  // 0*-inf
        v.push_back(mk(16'hFC00, 16'h3C00, 2'd0, 16'hFC00, 4'b0000));  // -inf*1
        v.push_back(mk(16'h7D00, 16'h3C00, 2'd0, 16'h7E00, 4'b1000));  // sNaN
        v.push_back(mk(16'h7E01, 16'h3C00, 2'd0, 16'h7E00, 4'b0000));  // qNaN
        v.push_back(mk(16'h8000, 16'h3C00, 2'd0, 16'h8000, 4'b0000));  // -0*1
        v.push_back(mk(16'h7C00, 16'h0001, 2'd0, 16'h7C00, 4'b0000));  // inf*subnormal
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].rm, 4'(i), o, f, t, lat);
            n_checks++; if (o !== v[i].o) begin n_fail++; $display("FAIL special[%0d] out: got %h expected %h", i, o, v[i].o); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL special[%0d] flags: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_underflow();
        logic [15:0] o; logic [3:0] f, t; int lat;
        vec_t v[$];
        v.push_back(mk(16'h0400, 16'h0400, 2'd0, 16'h0000, 4'b0011));  // 2^-28 flushes
        v.push_back(mk(16'h8400, 16'h0400, 2'd0, 16'h8000, 4'b0011));  // flush keeps sign
        v.push_back(mk(16'h8001, 16'h7800, 2'd0, 16'h9800, 4'b0000));  // -2^-24 * 2^15 = -2^-9
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].rm, 4'(i), o, f, t, lat);
            n_checks++; if (o !== v[i].o) begin n_fail++; $display("FAIL unf[%0d] out: got %h expected %h", i, o, v[i].o); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL unf[%0d] flags: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] o; logic [3:0] f, t; int lat;
        vec_t v[$];
        // (1+2^-10)^2 = 1 + 2^-9 + 2^-20: only sticky set
        v.push_back(mk(16'h3C01, 16'h3C01, 2'd0, 16'h3C02, 4'b0001));
        v.push_back(mk(16'h3C01, 16'h3C01, 2'd1, 16'h3C02, 4'b0001));
        v.push_back(mk(16'h3C01, 16'h3C01, 2'd2, 16'h3C03, 4'b0001));
        v.push_back(mk(16'hBC01, 16'h3C01, 2'd3, 16'hBC03, 4'b0001));
        v.push_back(mk(16'hBC01, 16'h3C01, 2'd2, 16'hBC02, 4'b0001));
        // exact ties: frac 0x201 + half -> 0x202, frac 0x204 + half -> stays
        v.push_back(mk(16'h3C01, 16'h3E00, 2'd0, 16'h3E02, 4'b0001));
        v.push_back(mk(16'h3C03, 16'h3E00, 2'd0, 16'h3E04, 4'b0001));
        // 2 - 2^-19: rounding carries into the exponent
        v.push_back(mk(16'h3FFE, 16'h3C01, 2'd0, 16'h4000, 4'b0001));
        v.push_back(mk(16'h3FFE, 16'h3C01, 2'd1, 16'h3FFF, 4'b0001));
        foreach (v[i]) begin
            do_op(v[i].a, v[i].b, v[i].rm, 4'(i), o, f, t, lat);
            n_checks++; if (o !== v[i].o) begin n_fail++; $display("FAIL round[%0d] out: got %h expected %h", i, o, v[i].o); end
            n_checks++; if (f !== v[i].f) begin n_fail++; $display("FAIL round[%0d] flags: got %b expected %b", i, f, v[i].f); end
        end
    endtask

    // 8 ops of 1.0 * 2^i (result 2^i, tag i), out_ready low on cycles 4..6.
    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0, stalls = 0;
        logic [15:0] held = '0;
        while ((sent < 8 || got < 8) && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 8) begin
                in_valid = 1'b1; a = 16'h3C00; b = 16'(16'h3C00 + (sent << 10));
                rm = 2'd0; in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b in_ready cyc %0d: got %b expected 0", cyc, in_ready); end
                if (stalls == 1) held = out;
                else begin
                    n_checks++; if (out !== held) begin n_fail++; $display("FAIL b2b hold cyc %0d: got %h expected %h", cyc, out, held); end
                end
            end
            if (out_valid && out_ready) begin
                n_checks++; if (out !== 16'(16'h3C00 + (got << 10))) begin n_fail++; $display("FAIL b2b out #%0d: got %h expected %h", got, out, 16'(16'h3C00 + (got << 10))); end
                n_checks++; if (out_tag !== 4'(got)) begin n_fail++; $display("FAIL b2b tag #%0d: got %h expected %h", got, out_tag, 4'(got)); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got !== 8)    begin n_fail++; $display("FAIL b2b count: got %0d results expected 8", got); end
        n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL b2b stall cycles: got %0d expected 3", stalls); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b extra result: got out_valid %b expected 0", out_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_flight();
        logic [15:0] o; logic [3:0] f, t; int lat; int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h3C00; b = 16'h4000; rm = 2'd0; in_tag = 4'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_flight busy: got out_valid %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_flight in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out !== 16'h0000)   begin n_fail++; $display("FAIL rst_flight out: got %h expected 0000", out); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) stale++;
            @(posedge clk); #1;
        end
        n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_flight stale: got %0d cycles expected 0", stale); end
        do_op(16'h3C00, 16'h4200, 2'd0, 4'h9, o, f, t, lat);
        n_checks++; if (lat !== 3)     begin n_fail++; $display("FAIL rst_flight latency: got %0d expected 3", lat); end
        n_checks++; if (o !== 16'h4200) begin n_fail++; $display("FAIL rst_flight out after: got %h expected 4200", o); end
        n_checks++; if (t !== 4'h9)    begin n_fail++; $display("FAIL rst_flight tag after: got %h expected 9", t); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_special();
        test_underflow();
        test_rounding();
        test_back_to_back();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
